tcm_dual_port_mem: RTL and testbench

//  Parametrised dual-port tightly-coupled memory (TCM) for the RV32I pipeline and its benches.

---
 rtl/tcm_pkg.sv | 31 +++
 rtl/tcm_read_pipe.sv | 50 +++++
 rtl/tcm_dual_port_mem.sv | 148 ++++++++++++++
 tb/tb_tcm_dual_port_mem.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcm_pkg.sv
//------------------------------------------------------------------------------
// Module : tcm_pkg
// Brief  : Shared helpers for the dual-port tightly-coupled memory.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package tcm_pkg;

    localparam int unsigned TCM_BYTE_W = 8;

    function automatic int unsigned be_width(input int unsigned data_w);
        return data_w / TCM_BYTE_W;
    endfunction

    // An address wrapped below the base becomes a huge offset, so one unsigned test covers both ends.
    function automatic logic in_range(input logic [31:0] off, input int unsigned span_bits);
        logic [63:0] w_wide;
        w_wide = {32'd0, off} >> span_bits;
        return (w_wide == 64'd0);
    endfunction

    function automatic logic [7:0] be_merge_byte(input logic [7:0] old_b,
                                                 input logic [7:0] new_b,
                                                 input logic       en);
        return en ? new_b : old_b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tcm_read_pipe.sv
//------------------------------------------------------------------------------
// Module : tcm_read_pipe
// Brief  : Valid/data/err shift register with a whole-pipeline hold.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tcm_read_pipe #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned DATA_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_hold,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_err,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_err
);

    logic [READ_LATENCY-1:0]             r_valid;
    logic [READ_LATENCY-1:0]             r_err;
    logic [READ_LATENCY-1:0][DATA_W-1:0] r_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_err   <= '0;
            r_data  <= '0;
        end else if (!i_hold) begin
            r_valid[0] <= i_valid;
            r_err[0]   <= i_err;
            r_data[0]  <= i_data;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                r_valid[i] <= r_valid[i-1];
                r_err[i]   <= r_err[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[READ_LATENCY-1];
    assign o_err   = r_err[READ_LATENCY-1];
    assign o_data  = r_data[READ_LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/tcm_dual_port_mem.sv
//------------------------------------------------------------------------------
// Module : tcm_dual_port_mem
// Brief  : Dual-port byte-enabled TCM with req/gnt, hold, range check and backdoor load.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tcm_dual_port_mem
    import tcm_pkg::*;
#(
    parameter int unsigned  ADDR_W        = 14,
    parameter int unsigned  DATA_W        = 32,
    parameter int unsigned  READ_LATENCY  = 1,
    parameter logic [31:0]  START_ADDRESS = 32'h0000_0000,
    parameter bit           FORWARD       = 1'b0,
    localparam int unsigned BE_W          = be_width(DATA_W),
    localparam int unsigned OFF_W         = $clog2(BE_W)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req0_i,
    input  logic                    req1_i,
    output logic                    gnt0_o,
    output logic                    gnt1_o,
    input  logic [31:0]             addr0_i,
    input  logic [31:0]             addr1_i,
    input  logic [BE_W-1:0]         wr0_i,
    input  logic [BE_W-1:0]         wr1_i,
    input  logic [DATA_W-1:0]       wdata0_i,
    input  logic [DATA_W-1:0]       wdata1_i,
    input  logic                    hold0_i,
    input  logic                    hold1_i,
    output logic                    rvalid0_o,
    output logic                    rvalid1_o,
    output logic [DATA_W-1:0]       rdata0_o,
    output logic [DATA_W-1:0]       rdata1_o,
    output logic                    err0_o,
    output logic                    err1_o,
    input  logic                    load_en_i,
    input  logic [ADDR_W+OFF_W-1:0] load_addr_i,
    input  logic [7:0]              load_data_i
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("tcm_dual_port_mem: READ_LATENCY must be in 1..4");
    end

    if (START_ADDRESS[OFF_W-1:0] != '0) begin : g_bad_base
        $error("tcm_dual_port_mem: START_ADDRESS must be word-aligned");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [31:0]       w_off0, w_off1;
    logic              w_in0, w_in1;
    logic              w_acc0, w_acc1;
    logic              w_we0, w_we1;
    logic [ADDR_W-1:0] w_idx0, w_idx1, w_ld_idx;
    logic [OFF_W-1:0]  w_ld_byte;
    logic [DATA_W-1:0] w_old0, w_old1, w_fwd1;
    logic [DATA_W-1:0] w_rd0, w_rd1;

    assign gnt0_o = req0_i & ~load_en_i & ~hold0_i;
    assign gnt1_o = req1_i & ~load_en_i & ~hold1_i;
    assign w_acc0 = req0_i & gnt0_o;
    assign w_acc1 = req1_i & gnt1_o;

    assign w_off0 = addr0_i - START_ADDRESS;
    assign w_off1 = addr1_i - START_ADDRESS;
    assign w_in0  = in_range(w_off0, ADDR_W + OFF_W);
    assign w_in1  = in_range(w_off1, ADDR_W + OFF_W);
    assign w_idx0 = w_off0[ADDR_W+OFF_W-1:OFF_W];
    assign w_idx1 = w_off1[ADDR_W+OFF_W-1:OFF_W];
    assign w_we0  = w_acc0 & w_in0 & (|wr0_i);
    assign w_we1  = w_acc1 & w_in1 & (|wr1_i);

    assign w_ld_idx  = load_addr_i[ADDR_W+OFF_W-1:OFF_W];
    assign w_ld_byte = load_addr_i[OFF_W-1:0];

    assign w_old0 = r_mem[w_idx0];
    assign w_old1 = r_mem[w_idx1];

    // Port-1 reads may see port-0's same-cycle store bytes; port-1 stores always return the old word.
    always_comb begin
        w_fwd1 = w_old1;
        if (FORWARD && w_we0 && (wr1_i == '0) && (w_idx0 == w_idx1)) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                w_fwd1[b*8 +: 8] = be_merge_byte(w_old1[b*8 +: 8], wdata0_i[b*8 +: 8], wr0_i[b]);
            end
        end
    end

    assign w_rd0 = w_in0 ? w_old0 : '0;
    assign w_rd1 = w_in1 ? w_fwd1 : '0;

    // Port 0 is written last so it owns any byte both ports enable.
    always_ff @(posedge clk_i) begin
        if (load_en_i) begin
            r_mem[w_ld_idx][{w_ld_byte, 3'b000} +: 8] <= load_data_i;
        end else begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (w_we1 && wr1_i[b]) begin
                    r_mem[w_idx1][b*8 +: 8] <= wdata1_i[b*8 +: 8];
                end
            end
            for (int b = 0; b < int'(BE_W); b++) begin
                if (w_we0 && wr0_i[b]) begin
                    r_mem[w_idx0][b*8 +: 8] <= wdata0_i[b*8 +: 8];
                end
            end
        end
    end

    tcm_read_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .DATA_W       (DATA_W)
    ) u_pipe0 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_hold  (hold0_i),
        .i_valid (w_acc0),
        .i_data  (w_rd0),
        .i_err   (w_acc0 & ~w_in0),
        .o_valid (rvalid0_o),
        .o_data  (rdata0_o),
        .o_err   (err0_o)
    );

    tcm_read_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .DATA_W       (DATA_W)
    ) u_pipe1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_hold  (hold1_i),
        .i_valid (w_acc1),
        .i_data  (w_rd1),
        .i_err   (w_acc1 & ~w_in1),
        .o_valid (rvalid1_o),
        .o_data  (rdata1_o),
        .o_err   (err1_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_tcm_dual_port_mem.sv
//------------------------------------------------------------------------------
// Module : tb_tcm_dual_port_mem
// Brief  : Scoreboard bench; two instances differ only in FORWARD.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tcm_dual_port_mem;

    localparam int          AW    = 8;
    localparam int          LAT   = 3;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0, req1, hold0, hold1, load_en;
    logic [31:0] addr0, addr1, wd0, wd1;
    logic [3:0]  wr0, wr1;
    logic [9:0]  load_addr;
    logic [7:0]  load_data;

    logic        gnt0a, gnt1a, rv0a, rv1a, er0a, er1a;
    logic        gnt0b, gnt1b, rv0b, rv1b, er0b, er1b;
    logic [31:0] rd0a, rd1a, rd0b, rd1b;

    always #5 clk = ~clk;

    tcm_dual_port_mem #(.ADDR_W(AW), .DATA_W(32), .READ_LATENCY(LAT),
                        .START_ADDRESS(BASE), .FORWARD(1'b1)) u_dut_fwd (
        .clk_i(clk), .rst_i(rst), .req0_i(req0), .req1_i(req1),
        .gnt0_o(gnt0a), .gnt1_o(gnt1a), .addr0_i(addr0), .addr1_i(addr1),
        .wr0_i(wr0), .wr1_i(wr1), .wdata0_i(wd0), .wdata1_i(wd1),
        .hold0_i(hold0), .hold1_i(hold1), .rvalid0_o(rv0a), .rvalid1_o(rv1a),
        .rdata0_o(rd0a), .rdata1_o(rd1a), .err0_o(er0a), .err1_o(er1a),
        .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
    );

    tcm_dual_port_mem #(.ADDR_W(AW), .DATA_W(32), .READ_LATENCY(LAT),
                        .START_ADDRESS(BASE), .FORWARD(1'b0)) u_dut_nofwd (
        .clk_i(clk), .rst_i(rst), .req0_i(req0), .req1_i(req1),
        .gnt0_o(gnt0b), .gnt1_o(gnt1b), .addr0_i(addr0), .addr1_i(addr1),
        .wr0_i(wr0), .wr1_i(wr1), .wdata0_i(wd0), .wdata1_i(wd1),
        .hold0_i(hold0), .hold1_i(hold1), .rvalid0_o(rv0b), .rvalid1_o(rv1b),
        .rdata0_o(rd0b), .rdata1_o(rd1b), .err0_o(er0b), .err1_o(er1b),
        .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
    );

    typedef struct {
        logic [31:0] d;
        logic [31:0] dn;
        logic        e;
        int          due;
    } ent_t;

    logic [31:0] mem [DEPTH];
    ent_t        q0[$], q1[$];
    ent_t        e0, e1, m0, m1;
    int          n_chk = 0, n_bad = 0;
    int          cyc = 0, fz0 = 0, fz1 = 0;
    bit          rst_edge, frz0_edge, frz1_edge;
    logic        m_g0, m_g1, m_in0, m_in1;
    int          m_i0, m_i1;
    logic [31:0] m_o0, m_o1;
    logic        p_rv0, p_rv1;
    logic [31:0] p_rd0, p_rd1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(DEPTH * 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off[9:2]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        for (int b = 0; b < 4; b++) if (be[b]) o[b*8 +: 8] = n[b*8 +: 8];
        return o;
    endfunction

    // Reference model: decides accepts, queues expected responses, updates its own memory.
    always @(posedge clk) begin
        cyc++;
        rst_edge  = rst;
        frz0_edge = 1'b0;
        frz1_edge = 1'b0;
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            m_g0 = req0 && !load_en && !hold0;
            m_g1 = req1 && !load_en && !hold1;
            if (hold0) begin fz0++; frz0_edge = 1'b1; end
            if (hold1) begin fz1++; frz1_edge = 1'b1; end
            m_in0 = in_rng(addr0);
            m_in1 = in_rng(addr1);
            m_i0  = widx(addr0);
            m_i1  = widx(addr1);
            m_o0  = m_in0 ? mem[m_i0] : 32'd0;
            m_o1  = m_in1 ? mem[m_i1] : 32'd0;
            if (m_g0) begin
                e0.d = m_o0; e0.dn = m_o0; e0.e = !m_in0; e0.due = cyc + LAT - 1 - fz0;
                q0.push_back(e0);
            end
            if (m_g1) begin
                e1.dn  = m_o1;
                e1.d   = (m_g0 && m_in0 && m_in1 && m_i0 == m_i1 && wr1 == 4'd0) ? merge(m_o1, wd0, wr0) : m_o1;
                e1.e   = !m_in1;
                e1.due = cyc + LAT - 1 - fz1;
                q1.push_back(e1);
            end
            if (load_en) begin
                mem[load_addr[9:2]][8*load_addr[1:0] +: 8] = load_data;
            end else begin
                if (m_g1 && m_in1) mem[m_i1] = merge(mem[m_i1], wd1, wr1);
                if (m_g0 && m_in0) mem[m_i0] = merge(mem[m_i0], wd0, wr0);
            end
        end
    end

    always @(negedge clk) begin
        chk("gnt0_fwd",   gnt0a, req0 && !load_en && !hold0);
        chk("gnt0_nofwd", gnt0b, req0 && !load_en && !hold0);
        chk("gnt1_fwd",   gnt1a, req1 && !load_en && !hold1);
        chk("gnt1_nofwd", gnt1b, req1 && !load_en && !hold1);
        if (rst_edge) begin
            chk("rst_rvalid0", rv0a, 1'b0);
            chk("rst_rvalid1", rv1a, 1'b0);
            chk("rst_rdata0",  rd0a, 32'd0);
            chk("rst_rdata1",  rd1a, 32'd0);
            chk("rst_err0",    er0a, 1'b0);
            chk("rst_err1",    er1a, 1'b0);
        end else begin
            if (frz0_edge) begin
                chk("hold_rvalid0", rv0a, p_rv0);
                chk("hold_rdata0",  rd0a, p_rd0);
            end else if (rv0a) begin
                chk("p0_rvalid_pending", rv0a, q0.size() > 0);
                if (q0.size() > 0) begin
                    m0 = q0.pop_front();
                    chk("p0_rdata",        rd0a, m0.d);
                    chk("p0_err",          er0a, m0.e);
                    chk("p0_latency",      cyc - fz0, m0.due);
                    chk("p0_nofwd_rvalid", rv0b, 1'b1);
                    chk("p0_nofwd_rdata",  rd0b, m0.dn);
                    chk("p0_nofwd_err",    er0b, m0.e);
                end
            end
            if (frz1_edge) begin
                chk("hold_rvalid1", rv1a, p_rv1);
                chk("hold_rdata1",  rd1a, p_rd1);
            end else if (rv1a) begin
                chk("p1_rvalid_pending", rv1a, q1.size() > 0);
                if (q1.size() > 0) begin
                    m1 = q1.pop_front();
                    chk("p1_rdata_fwd",    rd1a, m1.d);
                    chk("p1_err",          er1a, m1.e);
                    chk("p1_latency",      cyc - fz1, m1.due);
                    chk("p1_nofwd_rvalid", rv1b, 1'b1);
                    chk("p1_nofwd_rdata",  rd1b, m1.dn);
                    chk("p1_nofwd_err",    er1b, m1.e);
                end
            end
        end
        p_rv0 = rv0a; p_rd0 = rd0a;
        p_rv1 = rv1a; p_rd1 = rd1a;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic r, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        req0 = r; addr0 = a; wr0 = w; wd0 = d;
    endtask

    task automatic drive1(input logic r, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        req1 = r; addr1 = a; wr1 = w; wd1 = d;
    endtask

    task automatic idle();
        drive0(1'b0, BASE, 4'd0, 32'd0);
        drive1(1'b0, BASE, 4'd0, 32'd0);
        hold0 = 1'b0; hold1 = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    endtask

    task automatic load_word(input int w, input logic [31:0] v);
        for (int b = 0; b < 4; b++) begin
            load_en   = 1'b1;
            load_addr = {8'(w), 2'(b)};
            load_data = v[b*8 +: 8];
            tick();
        end
        load_en = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        if ($urandom_range(0, 7) == 0) return BASE + 32'h400 + 32'($urandom_range(0, 15)) * 4;
        return BASE + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        idle();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        for (int w = 0; w < 16; w++) load_word(w, 32'd0);
        load_word(255, 32'd0);
        load_word(5, 32'hDEADBEEF);

        // Reset during an in-flight read: the response must never appear.
        drive1(1'b1, BASE + 32'h14, 4'd0, 32'd0);
        tick();
        idle();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(6);

        // Latency-3 read of the backdoor word.
        drive1(1'b1, BASE + 32'h14, 4'd0, 32'd0);
        tick();
        idle();
        tick(5);

        // Byte-enable store into 0x11223344.
        drive0(1'b1, BASE + 32'hC, 4'hF, 32'h11223344);   tick();
        drive0(1'b1, BASE + 32'hC, 4'b0010, 32'h0000AB00); tick();
        drive0(1'b1, BASE + 32'hC, 4'd0, 32'd0);           tick();
        idle();
        tick(4);

        // Four back-to-back port-1 reads.
        drive1(1'b1, BASE + 32'h14, 4'd0, 32'd0); tick();
        drive1(1'b1, BASE + 32'h0C, 4'd0, 32'd0); tick();
        drive1(1'b1, BASE + 32'h14, 4'd0, 32'd0); tick();
        drive1(1'b1, BASE + 32'h00, 4'd0, 32'd0); tick();
        idle();
        tick(4);

        // Dual-port store collision on word 8, then read-during-write.
        drive0(1'b1, BASE + 32'h20, 4'b0011, 32'hAAAAAAAA);
        drive1(1'b1, BASE + 32'h20, 4'b0110, 32'hBBBBBBBB);
        tick();
        idle();
        drive1(1'b1, BASE + 32'h20, 4'd0, 32'd0);
        tick();
        drive0(1'b1, BASE + 32'h20, 4'hF, 32'h12345678);
        tick();
        drive0(1'b1, BASE + 32'h20, 4'b0001, 32'h000000FF);
        tick();
        idle();
        tick(4);

        // Out-of-range reads and dropped stores on both sides of the window.
        drive0(1'b1, 32'h0000_0FFC, 4'd0, 32'd0);        tick();
        drive0(1'b1, BASE + 32'h400, 4'd0, 32'd0);       tick();
        drive0(1'b1, BASE + 32'h400, 4'hF, 32'hCAFEF00D); tick();
        drive0(1'b1, 32'h0000_0FFC, 4'hF, 32'hCAFEF00D); tick();
        drive0(1'b1, BASE, 4'd0, 32'd0);                 tick();
        drive0(1'b1, BASE + 32'h3FC, 4'd0, 32'd0);       tick();
        idle();
        tick(4);

        // Hold port 0 for two cycles while a response is showing.
        drive0(1'b1, BASE + 32'h0C, 4'd0, 32'd0); tick();
        drive0(1'b1, BASE + 32'h14, 4'd0, 32'd0); tick();
        drive0(1'b1, BASE + 32'h20, 4'd0, 32'd0); tick();
        drive0(1'b1, BASE + 32'h00, 4'd0, 32'd0);
        drive1(1'b1, BASE + 32'h14, 4'd0, 32'd0);
        hold0 = 1'b1;
        tick(2);
        hold0 = 1'b0;
        tick();
        idle();
        tick(6);

        // Mixed traffic.
        for (int c = 0; c < 80; c++) begin
            drive0(1'($urandom_range(0, 1)), pick_addr(),
                   ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0, $urandom);
            drive1(1'($urandom_range(0, 1)), pick_addr(), 4'd0, 32'd0);
            hold0     = ($urandom_range(0, 5) == 0);
            hold1     = ($urandom_range(0, 5) == 0);
            load_en   = ($urandom_range(0, 9) == 0);
            load_addr = 10'($urandom_range(0, 63));
            load_data = 8'($urandom);
            tick();
        end
        idle();
        tick(10);

        chk("p0_drain", q0.size(), 0);
        chk("p1_drain", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
